// File: rtl/led_pkg.sv
// Shared constants, register layout and sweep state encoding for the LED blink counter controller.
package led_pkg;

    localparam logic [1:0] ADDR_CTRL     = 2'd0;
    localparam logic [1:0] ADDR_STATUS   = 2'd1;
    localparam logic [1:0] ADDR_EDGE_CNT = 2'd2;
    localparam logic [1:0] ADDR_SWEEP_N  = 2'd3;

    localparam int unsigned DIV_W             = 5;
    localparam int unsigned CTRL_DIV_LSB      = 0;
    localparam int unsigned CTRL_IRQ_EN_BIT   = 8;
    localparam int unsigned CTRL_SWEEP_EN_BIT = 9;
    localparam int unsigned SWEEP_N_W         = 8;
    localparam int unsigned EDGE_CNT_W        = 16;

    typedef enum logic [1:0] {IDLE, RUN, STEP} sweep_state_t;

    typedef struct packed {
        logic             sweep_en;
        logic             irq_en;
        logic [DIV_W-1:0] div;
    } ctrl_t;

    // Sweep successor: 1..div_max then back to 1; out-of-range values restart at 1.
    function automatic logic [DIV_W-1:0] sweep_next_div(input logic [DIV_W-1:0] div,
                                                        input int unsigned div_max);
        if (div == '0 || div >= DIV_W'(div_max))
            return DIV_W'(1);
        return div + DIV_W'(1);
    endfunction

endpackage

// File: rtl/led_cnt_ctrl_if.sv
// Host register bus between the PS glue (master) and the LED counter controller (slave).
interface led_cnt_ctrl_if #(
    parameter int unsigned DATA_W = 32
) ();
    logic              bus_wr_i;
    logic              bus_rd_i;
    logic [1:0]        bus_addr_i;
    logic [DATA_W-1:0] bus_wdata_i;
    logic [DATA_W-1:0] bus_rdata_o;
    logic              bus_rvalid_o;

    modport master (
        output bus_wr_i, bus_rd_i, bus_addr_i, bus_wdata_i,
        input  bus_rdata_o, bus_rvalid_o
    );

    modport slave (
        input  bus_wr_i, bus_rd_i, bus_addr_i, bus_wdata_i,
        output bus_rdata_o, bus_rvalid_o
    );
endinterface

// File: rtl/led_sweep_fsm.sv
// Divider sweep sequencer: counts LED edges and requests a divider step every N edges.
module led_sweep_fsm
    import led_pkg::*;
#(
    parameter int unsigned DIV_MAX = 20
) (
    input  logic                 clk100,
    input  logic                 rst,
    input  logic                 sweep_en,
    input  logic [SWEEP_N_W-1:0] sweep_n,
    input  logic                 led_int,
    input  logic [DIV_W-1:0]     div,
    output logic                 step,
    output logic [DIV_W-1:0]     next_div_c,
    output sweep_state_t         state
);

    logic [SWEEP_N_W-1:0] cnt;
    logic [SWEEP_N_W-1:0] n_eff_c;
    logic [SWEEP_N_W:0]   cnt_inc_c;

    // A programmed N of 0 behaves as 1.
    assign n_eff_c    = (sweep_n == '0) ? SWEEP_N_W'(1) : sweep_n;
    assign cnt_inc_c  = {1'b0, cnt} + (SWEEP_N_W + 1)'(1);
    assign next_div_c = sweep_next_div(div, DIV_MAX);

    always_ff @(posedge clk100) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            step  <= 1'b0;
        end else begin
            step <= 1'b0;
            if (!sweep_en) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= RUN;
                        cnt   <= '0;
                    end
                    RUN: begin
                        if (led_int) begin
                            if (cnt_inc_c >= {1'b0, n_eff_c}) begin
                                state <= STEP;
                                step  <= 1'b1;
                                cnt   <= '0;
                            end else begin
                                cnt <= cnt_inc_c[SWEEP_N_W-1:0];
                            end
                        end
                    end
                    STEP: begin
                        state <= RUN;
                        cnt   <= '0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/led_cnt_ctrl.sv
// Register-side controller for the LED blink counter: divider/restart drive, edge IRQ, sweep.
// Optional edge counter at address 2 is built only when LED_EDGE_CNT_EN is defined.
module led_cnt_ctrl
    import led_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned DIV_MAX = 20,
    parameter int unsigned DIV_RST = 1
) (
    input  logic             clk100,
    input  logic             rst,
    led_cnt_ctrl_if.slave    bus,
    output logic [DIV_W-1:0] div_o,
    output logic             wren_o,
    input  logic             led_i,
    input  logic             led_int_i,
    output logic             irq_o
);

    ctrl_t                 ctrl;
    logic                  pending;
    logic [SWEEP_N_W-1:0]  sweep_n;
    logic                  ctrl_upd;
    logic                  sweep_step;
    logic [DIV_W-1:0]      sweep_div_c;
    sweep_state_t          sweep_state;

    logic                  wr_ctrl_c;
    logic                  wr_status_c;
    logic                  wr_sweep_n_c;
    logic                  do_step_c;
    logic [EDGE_CNT_W-1:0] edge_rd_c;
    logic [DATA_W-1:0]     rd_val_c;
    logic                  unused_c;

    assign wr_ctrl_c    = bus.bus_wr_i && (bus.bus_addr_i == ADDR_CTRL);
    assign wr_status_c  = bus.bus_wr_i && (bus.bus_addr_i == ADDR_STATUS);
    assign wr_sweep_n_c = bus.bus_wr_i && (bus.bus_addr_i == ADDR_SWEEP_N);
    // A host CTRL write in the step cycle overrides the sweep step.
    assign do_step_c    = sweep_step && ctrl.sweep_en && !wr_ctrl_c;

    led_sweep_fsm #(.DIV_MAX(DIV_MAX)) u_sweep (
        .clk100     (clk100),
        .rst        (rst),
        .sweep_en   (ctrl.sweep_en),
        .sweep_n    (sweep_n),
        .led_int    (led_int_i),
        .div        (ctrl.div),
        .step       (sweep_step),
        .next_div_c (sweep_div_c),
        .state      (sweep_state)
    );

    // Register file, divider drive (one cycle behind CTRL, aligned with wren_o) and IRQ.
    always_ff @(posedge clk100) begin
        if (rst) begin
            ctrl.div      <= DIV_W'(DIV_RST);
            ctrl.irq_en   <= 1'b0;
            ctrl.sweep_en <= 1'b0;
            pending       <= 1'b0;
            sweep_n       <= '0;
            ctrl_upd      <= 1'b0;
            div_o         <= DIV_W'(DIV_RST);
            wren_o        <= 1'b0;
            irq_o         <= 1'b0;
        end else begin
            if (wr_ctrl_c) begin
                ctrl.div      <= bus.bus_wdata_i[CTRL_DIV_LSB +: DIV_W];
                ctrl.irq_en   <= bus.bus_wdata_i[CTRL_IRQ_EN_BIT];
                ctrl.sweep_en <= bus.bus_wdata_i[CTRL_SWEEP_EN_BIT];
            end else if (do_step_c) begin
                ctrl.div <= sweep_div_c;
            end
            if (wr_sweep_n_c)
                sweep_n <= bus.bus_wdata_i[SWEEP_N_W-1:0];
            pending  <= led_int_i || (pending && !(wr_status_c && bus.bus_wdata_i[0]));
            ctrl_upd <= wr_ctrl_c || do_step_c;
            div_o    <= ctrl.div;
            wren_o   <= ctrl_upd;
            irq_o    <= pending && ctrl.irq_en;
        end
    end

`ifdef LED_EDGE_CNT_EN
    logic                  wr_edge_c;
    logic [EDGE_CNT_W-1:0] edge_cnt;

    assign wr_edge_c = bus.bus_wr_i && (bus.bus_addr_i == ADDR_EDGE_CNT);

    // Any write clears, and the clear wins over a coincident pulse.
    always_ff @(posedge clk100) begin
        if (rst)
            edge_cnt <= '0;
        else if (wr_edge_c)
            edge_cnt <= '0;
        else if (led_int_i)
            edge_cnt <= edge_cnt + EDGE_CNT_W'(1);
    end

    assign edge_rd_c = edge_cnt;
`else
    assign edge_rd_c = '0;
`endif

    always_comb begin
        rd_val_c = '0;
        case (bus.bus_addr_i)
            ADDR_CTRL: begin
                rd_val_c[CTRL_DIV_LSB +: DIV_W]  = ctrl.div;
                rd_val_c[CTRL_IRQ_EN_BIT]        = ctrl.irq_en;
                rd_val_c[CTRL_SWEEP_EN_BIT]      = ctrl.sweep_en;
            end
            ADDR_STATUS:   rd_val_c[1:0]            = {led_i, pending};
            ADDR_EDGE_CNT: rd_val_c[EDGE_CNT_W-1:0] = edge_rd_c;
            ADDR_SWEEP_N:  rd_val_c[SWEEP_N_W-1:0]  = sweep_n;
            default: ;
        endcase
    end

    // Read data is captured from pre-write state and held until the next read.
    always_ff @(posedge clk100) begin
        if (rst) begin
            bus.bus_rdata_o  <= '0;
            bus.bus_rvalid_o <= 1'b0;
        end else begin
            bus.bus_rvalid_o <= bus.bus_rd_i;
            if (bus.bus_rd_i)
                bus.bus_rdata_o <= rd_val_c;
        end
    end

    assign unused_c = ^{bus.bus_wdata_i[DATA_W-1:10], sweep_state};

endmodule

// File: tb/tb_led_cnt_ctrl.sv
// Directed self-checking bench for led_cnt_ctrl (edge counter expectations follow LED_EDGE_CNT_EN).
module tb_led_cnt_ctrl;
    import led_pkg::*;

`ifdef LED_EDGE_CNT_EN
    localparam logic EDGE_EN = 1'b1;
`else
    localparam logic EDGE_EN = 1'b0;
`endif

    logic       clk100 = 1'b0;
    logic       rst;
    logic [4:0] div_o;
    logic       wren_o;
    logic       led_i;
    logic       led_int_i;
    logic       irq_o;
    int         total  = 0;
    int         passed = 0;

    led_cnt_ctrl_if #(.DATA_W(32)) bus ();

    led_cnt_ctrl #(.DATA_W(32), .DIV_MAX(20), .DIV_RST(1)) dut (
        .clk100    (clk100),
        .rst       (rst),
        .bus       (bus),
        .div_o     (div_o),
        .wren_o    (wren_o),
        .led_i     (led_i),
        .led_int_i (led_int_i),
        .irq_o     (irq_o)
    );

    always #5 clk100 = ~clk100;

    task automatic tick();
        @(posedge clk100);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.bus_wr_i = 1'b1; bus.bus_addr_i = a; bus.bus_wdata_i = d;
        tick();
        bus.bus_wr_i = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
        bus.bus_rd_i = 1'b1; bus.bus_addr_i = a;
        tick();
        bus.bus_rd_i = 1'b0;
        chk({tag, "_rvalid"}, 32'(bus.bus_rvalid_o), 32'd1);
        chk(tag, bus.bus_rdata_o, exp);
    endtask

    task automatic pulse();
        led_int_i = 1'b1;
        tick();
        led_int_i = 1'b0;
        tick();
    endtask

    // Watch n cycles: count wren_o pulses and confirm the divider at the end.
    task automatic watch(input string tag, input int n, input int exp_cnt, input logic [4:0] exp_div);
        int c = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (wren_o) c++;
        end
        chk({tag, "_wren_cnt"}, 32'(c), 32'(exp_cnt));
        chk({tag, "_div"}, 32'(div_o), 32'(exp_div));
    endtask

    initial begin
        rst = 1'b1; led_i = 1'b0; led_int_i = 1'b0;
        bus.bus_wr_i = 1'b0; bus.bus_rd_i = 1'b0; bus.bus_addr_i = 2'd0; bus.bus_wdata_i = '0;
        tick(); tick();
        chk("rst_div", 32'(div_o), 32'd1);
        chk("rst_wren", 32'(wren_o), 32'd0);
        chk("rst_irq", 32'(irq_o), 32'd0);
        chk("rst_rdata", bus.bus_rdata_o, 32'd0);
        chk("rst_rvalid", 32'(bus.bus_rvalid_o), 32'd0);
        rst = 1'b0;
        tick();

        rd_chk("rd_ctrl0", ADDR_CTRL, 32'h001);
        rd_chk("rd_status0", ADDR_STATUS, 32'h0);
        rd_chk("rd_edge0", ADDR_EDGE_CNT, 32'h0);
        rd_chk("rd_sweep0", ADDR_SWEEP_N, 32'h0);

        // CTRL write: wren_o and new div two cycles after the strobe
        wr(ADDR_CTRL, 32'h105);
        chk("ctrl_wren_e1", 32'(wren_o), 32'd0);
        chk("ctrl_div_e1", 32'(div_o), 32'd1);
        tick();
        chk("ctrl_wren_e2", 32'(wren_o), 32'd1);
        chk("ctrl_div_e2", 32'(div_o), 32'd5);
        tick();
        chk("ctrl_wren_e3", 32'(wren_o), 32'd0);
        rd_chk("rd_ctrl1", ADDR_CTRL, 32'h105);
        tick();
        chk("rvalid_drop", 32'(bus.bus_rvalid_o), 32'd0);
        chk("rdata_hold", bus.bus_rdata_o, 32'h105);

        // Pending / IRQ
        led_int_i = 1'b1;
        tick();
        led_int_i = 1'b0;
        chk("irq_lat0", 32'(irq_o), 32'd0);
        tick();
        chk("irq_set", 32'(irq_o), 32'd1);
        led_int_i = 1'b1;
        wr(ADDR_STATUS, 32'h1);
        led_int_i = 1'b0;
        rd_chk("pend_set_wins", ADDR_STATUS, 32'h1);
        chk("irq_still", 32'(irq_o), 32'd1);
        wr(ADDR_STATUS, 32'h1);
        chk("irq_clr_lat", 32'(irq_o), 32'd1);
        tick();
        chk("irq_clr", 32'(irq_o), 32'd0);
        led_i = 1'b1;
        rd_chk("status_led", ADDR_STATUS, 32'h2);
        led_i = 1'b0;

        // Edge counter (two pulses so far)
        rd_chk("edge_2", ADDR_EDGE_CNT, EDGE_EN ? 32'd2 : 32'd0);
        wr(ADDR_EDGE_CNT, 32'h1234);
        rd_chk("edge_clr", ADDR_EDGE_CNT, 32'd0);
        pulse(); pulse(); pulse();
        rd_chk("edge_3", ADDR_EDGE_CNT, EDGE_EN ? 32'd3 : 32'd0);
        led_int_i = 1'b1;
        wr(ADDR_EDGE_CNT, 32'h0);
        led_int_i = 1'b0;
        rd_chk("edge_clr_wins", ADDR_EDGE_CNT, 32'd0);
`ifdef LED_EDGE_CNT_EN
        led_int_i = 1'b1;
        for (int i = 0; i < 65535; i++) tick();
        led_int_i = 1'b0;
        rd_chk("edge_ffff", ADDR_EDGE_CNT, 32'hFFFF);
        pulse();
        rd_chk("edge_wrap", ADDR_EDGE_CNT, 32'h0);
`endif
        wr(ADDR_STATUS, 32'h1);

        // SWEEP_N read-during-write returns the old value
        wr(ADDR_SWEEP_N, 32'h5A);
        bus.bus_rd_i = 1'b1;
        wr(ADDR_SWEEP_N, 32'h102);
        bus.bus_rd_i = 1'b0;
        chk("rdwr_old", bus.bus_rdata_o, 32'h5A);
        rd_chk("sweep_n2", ADDR_SWEEP_N, 32'h02);

        // Sweep 19 -> 20 -> 1 with N=2
        wr(ADDR_CTRL, 32'h213);
        watch("sw_start", 4, 1, 5'd19);
        pulse(); pulse();
        watch("sw_step20", 5, 1, 5'd20);
        pulse(); pulse();
        watch("sw_wrap1", 5, 1, 5'd1);

        // CTRL write landing in the STEP cycle
        pulse();
        led_int_i = 1'b1;
        tick();
        led_int_i = 1'b0;
        wr(ADDR_CTRL, 32'h207);
        watch("sw_conflict", 5, 1, 5'd7);

        // Reset in the middle of RUN
        pulse();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_div", 32'(div_o), 32'd1);
        chk("midrst_wren", 32'(wren_o), 32'd0);
        chk("midrst_state", 32'(dut.u_sweep.state), 32'(IDLE));
        watch("midrst_quiet", 4, 0, 5'd1);

        // N=0 acts as 1; sweep from div=0 goes to 1
        wr(ADDR_CTRL, 32'h200);
        watch("n0_start", 4, 1, 5'd0);
        pulse();
        watch("n0_step", 5, 1, 5'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
